// File: rtl/exec_mul_seq_pkg.sv
// ============================================================================
// Module : exec_mul_seq_pkg
// Brief  : Shared widths and state encoding for the EX-stage multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef REG_SIZE
`define REG_SIZE 32
`endif

`ifndef REG_ADDR
`define REG_ADDR 5
`endif

package exec_mul_seq_pkg;

    typedef logic [1:0] mul_state_t;

    localparam mul_state_t MUL_IDLE = 2'd0;
    localparam mul_state_t MUL_BUSY = 2'd1;
    localparam mul_state_t MUL_DONE = 2'd2;

    localparam int unsigned C_REG_SIZE = `REG_SIZE;
    localparam int unsigned C_REG_ADDR = `REG_ADDR;

endpackage : exec_mul_seq_pkg

`default_nettype wire

// File: rtl/exec_mul_seq_mul_step.sv
// ============================================================================
// Module : mul_step
// Brief  : One shift-add iteration: conditional add into the upper half, then
//          shift accumulator and multiplier right by one.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0]   o_mplier
);

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;

    assign w_addend = i_mplier[0] ? i_mcand : '0;

    // The carry out of the upper half becomes the new MSB after the shift.
    assign w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign o_acc    = {w_sum, i_acc[WIDTH-1:1]};
    assign o_mplier = {1'b0, i_mplier[WIDTH-1:1]};

endmodule : mul_step

`default_nettype wire

// File: rtl/exec_mul_seq.sv
// ============================================================================
// Module : exec_mul_seq
// Brief  : Iterative one-bit-per-cycle multiplier sequencer for the EX stage.
//          Optional EXEC_MUL_EARLY_EXIT_EN ends the loop once the remaining
//          multiplier bits are zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exec_mul_seq
    import exec_mul_seq_pkg::*;
#(
    parameter int WIDTH = `REG_SIZE,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    input  logic [`REG_ADDR-1:0] wreg_in,
    input  logic                 regwrite_in,
    input  logic                 flush,
    output logic                 stall,
    output logic                 done,
    output logic [WIDTH-1:0]     result_lo,
    output logic [WIDTH-1:0]     result_hi,
    output logic                 overflow,
    output logic [`REG_ADDR-1:0] wreg_out,
    output logic                 regwrite_out
);

    mul_state_t           r_state;
    mul_state_t           w_next_state;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic                 r_signed;
    logic [`REG_ADDR-1:0] r_wreg;
    logic                 r_regwrite;
    logic [WIDTH-1:0]     r_res_lo;
    logic [WIDTH-1:0]     r_res_hi;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_busy;
    logic                 w_last_step;
    logic                 w_finish;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic [2*WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]     w_step_mplier;
    logic [2*WIDTH-1:0]   w_final_acc;
    logic [2*WIDTH-1:0]   w_prod;
    logic                 w_ovf;

    assign w_accept    = (r_state == MUL_IDLE) & start & ~flush;
    assign w_busy      = (r_state == MUL_BUSY);
    assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

    // Magnitudes of the operands; the most negative value maps to 2^(WIDTH-1).
    assign w_mag1 = (is_signed & src1[WIDTH-1]) ? (~src1 + 1'b1) : src1;
    assign w_mag2 = (is_signed & src2[WIDTH-1]) ? (~src2 + 1'b1) : src2;

    mul_step #(
        .WIDTH    (WIDTH)
    ) u_mul_step (
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_step_acc),
        .o_mplier (w_step_mplier)
    );

`ifdef EXEC_MUL_EARLY_EXIT_EN
    logic             w_mplier_zero;
    logic [CNT_W:0]   w_shamt;

    // With no set multiplier bits left, the remaining steps are pure shifts.
    assign w_mplier_zero = (r_mplier == '0);
    assign w_shamt       = (CNT_W + 1)'(WIDTH) - {1'b0, r_cnt};
    assign w_finish      = w_last_step | w_mplier_zero;
    assign w_final_acc   = w_mplier_zero ? (r_acc >> w_shamt) : w_step_acc;
`else
    assign w_finish      = w_last_step;
    assign w_final_acc   = w_step_acc;
`endif

    assign w_prod = r_neg ? (~w_final_acc + 1'b1) : w_final_acc;

    always_comb begin
        w_ovf = 1'b0;
        if (r_signed) begin
            w_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
        end else begin
            w_ovf = (w_prod[2*WIDTH-1:WIDTH] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= MUL_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MUL_IDLE: begin
                if (w_accept) begin
                    w_next_state = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (flush) begin
                    w_next_state = MUL_IDLE;
                end else if (w_finish) begin
                    w_next_state = MUL_DONE;
                end
            end
            MUL_DONE: begin
                w_next_state = MUL_IDLE;
            end
            default: begin
                w_next_state = MUL_IDLE;
            end
        endcase
    end

    // A flush landing in DONE suppresses the completion pulse of that op.
    always_comb begin
        stall        = w_accept | w_busy;
        done         = (r_state == MUL_DONE) & ~flush;
        regwrite_out = (r_state == MUL_DONE) & ~flush & r_regwrite;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_signed   <= 1'b0;
            r_wreg     <= '0;
            r_regwrite <= 1'b0;
            r_res_lo   <= '0;
            r_res_hi   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mcand    <= w_mag1;
                r_mplier   <= w_mag2;
                r_acc      <= '0;
                r_cnt      <= '0;
                r_neg      <= is_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
                r_signed   <= is_signed;
                r_wreg     <= wreg_in;
                r_regwrite <= regwrite_in;
            end else if (w_busy && !flush) begin
                r_acc    <= w_step_acc;
                r_mplier <= w_step_mplier;
                r_cnt    <= r_cnt + CNT_W'(1);
                if (w_finish) begin
                    r_res_lo <= w_prod[WIDTH-1:0];
                    r_res_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_ovf    <= w_ovf;
                end
            end
        end
    end

    assign result_lo = r_res_lo;
    assign result_hi = r_res_hi;
    assign overflow  = r_ovf;
    assign wreg_out  = r_wreg;

endmodule : exec_mul_seq

`default_nettype wire

// File: tb/tb_exec_mul_seq.sv
// ============================================================================
// Module : tb_exec_mul_seq
// Brief  : Directed and randomized self-checking bench for exec_mul_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exec_mul_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  wreg_in;
    logic        regwrite_in;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        overflow;
    logic [4:0]  wreg_out;
    logic        regwrite_out;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] last_prod = 64'd0;

    always #5 clk = ~clk;

    exec_mul_seq u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .is_signed    (is_signed),
        .src1         (src1),
        .src2         (src2),
        .wreg_in      (wreg_in),
        .regwrite_in  (regwrite_in),
        .flush        (flush),
        .stall        (stall),
        .done         (done),
        .result_lo    (result_lo),
        .result_hi    (result_hi),
        .overflow     (overflow),
        .wreg_out     (wreg_out),
        .regwrite_out (regwrite_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic ref_ovf(input logic [63:0] p, input logic sgn);
        longint sp;
        sp = longint'(p);
        if (sgn) return (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
        return p > 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic int ref_latency(input logic [31:0] b, input logic sgn);
`ifdef EXEC_MUL_EARLY_EXIT_EN
        logic [31:0] mag;
        int k;
        mag = (sgn && b[31]) ? (32'd0 - b) : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
        return (k + 2 > 33) ? 33 : k + 2;
`else
        return 33 + 0 * int'({sgn, b[0]});
`endif
    endfunction

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [4:0] wr, input logic rw);
        logic [63:0] p;
        int cyc;
        int lat;
        p   = ref_prod(a, b, sgn);
        lat = ref_latency(b, sgn);
        @(posedge clk); #1;
        start = 1'b1; is_signed = sgn; src1 = a; src2 = b; wreg_in = wr; regwrite_in = rw;
        #1;
        chk("stall_cycle0", stall, 1);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0; src1 = $urandom; src2 = $urandom; wreg_in = 5'(~wr);
                regwrite_in = ~rw;
            end
            if (done === 1'b1) break;
            chk("stall_busy", stall, 1);
        end
        chk("latency", 64'(cyc), 64'(lat));
        chk("result_lo", result_lo, p[31:0]);
        chk("result_hi", result_hi, p[63:32]);
        chk("overflow", overflow, ref_ovf(p, sgn));
        chk("wreg_out", wreg_out, wr);
        chk("regwrite_out_done", regwrite_out, rw);
        chk("stall_done", stall, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("regwrite_out_idle", regwrite_out, 0);
        chk("hold_lo", result_lo, p[31:0]);
        chk("hold_hi", result_hi, p[63:32]);
        last_prod = p;
    endtask

    initial begin
        int done_seen;
        logic [31:0] ra, rb;
        logic rs;

        reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; src1 = '0; src2 = '0;
        wreg_in = '0; regwrite_in = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_lo", result_lo, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_wreg", wreg_out, 0);
        chk("rst_regwrite", regwrite_out, 0);
        reset_n = 1'b1;

        do_mul(32'd7, 32'd6, 1'b0, 5'd3, 1'b1);
        do_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 5'd9, 1'b1);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd31, 1'b0);
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 5'd1, 1'b1);
        do_mul(32'h8000_0000, 32'd1, 1'b1, 5'd2, 1'b1);
        do_mul(32'h1234_5678, 32'd0, 1'b1, 5'd4, 1'b1);
        do_mul(32'd9, 32'd1, 1'b0, 5'd5, 1'b1);
        do_mul(32'd0, 32'hDEAD_BEEF, 1'b0, 5'd6, 1'b0);
        do_mul(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd7, 1'b1);

        // Flush in BUSY cycle 10: no completion, results untouched.
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b0; src1 = 32'd100; src2 = 32'd200;
        wreg_in = 5'd12; regwrite_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        chk("flush_stall_busy", stall, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_stall_idle", stall, 0);
        chk("flush_done", done, 0);
        chk("flush_regwrite", regwrite_out, 0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || regwrite_out === 1'b1) done_seen++;
        end
        chk("flush_no_pulse", 64'(done_seen), 0);
        chk("flush_hold_lo", result_lo, last_prod[31:0]);
        do_mul(32'd2, 32'd3, 1'b0, 5'd8, 1'b1);

        // Reset in BUSY cycle 5.
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b1; src1 = 32'hFFFF_0000; src2 = 32'd77;
        wreg_in = 5'd21; regwrite_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_done", done, 0);
        chk("midrst_lo", result_lo, 0);
        chk("midrst_hi", result_hi, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_wreg", wreg_out, 0);
        chk("midrst_regwrite", regwrite_out, 0);
        reset_n = 1'b1;
        do_mul(32'hFFFF_0000, 32'd77, 1'b1, 5'd21, 1'b1);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            rs = 1'($urandom_range(0, 1));
            do_mul(ra, rb, rs, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_exec_mul_seq

`default_nettype wire
